// File: rtl/stream_range_pkg.sv
// Shared types for the stream_range slice: FSM state encoding and default word width.
package stream_range_pkg;

  localparam int N_DEFAULT = 8;

  // DRAIN is only reachable when the output skid buffer is built in.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/stream_range_skid.sv
// Generic W-wide 2-entry valid/ready skid buffer.
// Latency: 1 cycle from up handshake to dn_vld.
// Backpressure: up_rdy = not full, taken from the occupancy register only (no comb path from dn_rdy).
module stream_range_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         up_vld,
  output logic         up_rdy,
  input  logic [W-1:0] up_dat,
  output logic         dn_vld,
  input  logic         dn_rdy,
  output logic [W-1:0] dn_dat
);

  logic [1:0]   cnt;
  logic [W-1:0] buf0;
  logic [W-1:0] buf1;
  logic         push;
  logic         pop;

  assign up_rdy = (cnt != 2'd2);
  assign dn_vld = (cnt != 2'd0);
  assign dn_dat = buf0;
  assign push   = up_vld & up_rdy;
  assign pop    = dn_vld & dn_rdy;

  // buf0 is always the head; buf1 only holds a word while the consumer stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= 2'd0;
      buf0 <= '0;
      buf1 <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) buf0 <= up_dat;
          else             buf1 <= up_dat;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          buf0 <= buf1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            buf0 <= up_dat;
          end else begin
            buf0 <= buf1;
            buf1 <= up_dat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/stream_range.sv
// Range stream source: lo, lo+step, ... <= hi on sOut, then a held completion flag.
// Latency: first word 1 cycle after start (2 with STREAM_RANGE_SKID_EN); 1 word/cycle sustained.
// Backpressure: sOut_ready stalls the generator; with STREAM_RANGE_SKID_EN it only sees skid-not-full.
module stream_range
  import stream_range_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] lo,
  input  logic [N-1:0] hi,
  input  logic [N-1:0] step,
  output logic [N-1:0] sOut,
  output logic         sOut_valid,
  input  logic         sOut_ready,
  output logic         out_valid,
  input  logic         out_ready
);

  state_t       state;
  state_t       state_nxt;
  logic [N-1:0] cur;
  logic [N-1:0] hi_r;
  logic [N-1:0] step_r;
  logic [N:0]   nxt;
  logic         gen_vld;
  logic         gen_rdy;
  logic         gen_acc;
  logic         gen_last;
  logic         drain_done;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign gen_vld   = (state == RUN);
  assign gen_acc   = gen_vld & gen_rdy;

  // Carry out of N bits ends the range so it never wraps; step 0 emits exactly one word.
  assign nxt      = {1'b0, cur} + {1'b0, step_r};
  assign gen_last = nxt[N] | (nxt[N-1:0] > hi_r) | (step_r == '0);

`ifdef STREAM_RANGE_SKID_EN
  localparam state_t RUN_EXIT = DRAIN;

  stream_range_skid #(.W(N)) u_skid (
    .clk    (clk),
    .reset  (reset),
    .up_vld (gen_vld),
    .up_rdy (gen_rdy),
    .up_dat (cur),
    .dn_vld (sOut_valid),
    .dn_rdy (sOut_ready),
    .dn_dat (sOut)
  );

  assign drain_done = ~sOut_valid;
`else
  localparam state_t RUN_EXIT = DONE;

  assign sOut       = cur;
  assign sOut_valid = gen_vld;
  assign gen_rdy    = sOut_ready;
  assign drain_done = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (in_valid) state_nxt = (lo > hi) ? DONE : RUN;
      RUN:   if (gen_acc && gen_last) state_nxt = RUN_EXIT;
      DRAIN: if (drain_done) state_nxt = DONE;
      DONE:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cur    <= '0;
      hi_r   <= '0;
      step_r <= '0;
    end else begin
      state <= state_nxt;
      if (in_ready && in_valid) begin
        cur    <= lo;
        hi_r   <= hi;
        step_r <= step;
      end else if (gen_acc && !gen_last) begin
        cur <= nxt[N-1:0];
      end
    end
  end

endmodule

// File: tb/tb_stream_range.sv
// Randomised self-checking bench for stream_range against a queue-based range model.
module tb_stream_range;

  localparam int N = 8;
`ifdef STREAM_RANGE_SKID_EN
  localparam int LAT     = 2;
  localparam int DRAIN_X = 1;
`else
  localparam int LAT     = 1;
  localparam int DRAIN_X = 0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] lo;
  logic [N-1:0] hi;
  logic [N-1:0] step;
  logic [N-1:0] sOut;
  logic         sOut_valid;
  logic         sOut_ready;
  logic         out_valid;
  logic         out_ready;

  int errors = 0;
  int checks = 0;

  stream_range #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .lo         (lo),
    .hi         (hi),
    .step       (step),
    .sOut       (sOut),
    .sOut_valid (sOut_valid),
    .sOut_ready (sOut_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: always ready, 1: random ready, 2: ready pattern 1,0,0,1,0,0...
  task automatic run_range(input int lo_v, input int hi_v, input int step_v,
                           input int mode, input string tag, output int sum);
    int   q[$];
    int   got[$];
    int   v;
    int   cyc;
    int   first_vld;
    int   last_acc;
    int   done_cyc;
    logic stalled;
    logic [N-1:0] held;

    v = lo_v;
    while (v <= hi_v) begin
      q.push_back(v);
      if (step_v == 0) break;
      v += step_v;
    end

    check_eq({tag, " idle_ready"}, int'(in_ready), 1);
    lo = N'(lo_v); hi = N'(hi_v); step = N'(step_v);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lo = 8'($urandom); hi = 8'($urandom); step = 8'($urandom);

    cyc = 1; first_vld = -1; last_acc = -1; done_cyc = -1; stalled = 1'b0; held = '0;
    forever begin
      if (cyc >= 3000) begin
        check_eq({tag, " timeout"}, 0, 1);
        break;
      end
      if (stalled) begin
        check_eq({tag, " stall_vld"}, int'(sOut_valid), 1);
        check_eq({tag, " stall_dat"}, int'(sOut), int'(held));
      end
      if (out_valid) begin
        done_cyc = cyc;
        break;
      end
      case (mode)
        0:       sOut_ready = 1'b1;
        1:       sOut_ready = 1'($urandom_range(0, 1));
        default: sOut_ready = ((cyc % 3) == 1);
      endcase
      if (sOut_valid && first_vld < 0) first_vld = cyc;
      if (sOut_valid && sOut_ready) begin
        got.push_back(int'(sOut));
        last_acc = cyc;
      end
      stalled = sOut_valid & ~sOut_ready;
      held    = sOut;
      tick();
      cyc++;
    end

    sum = 0;
    foreach (got[i]) sum += got[i];
    check_eq({tag, " count"}, got.size(), q.size());
    for (int i = 0; i < q.size() && i < got.size(); i++)
      check_eq($sformatf("%s word%0d", tag, i), got[i], q[i]);
    if (q.size() == 0) begin
      check_eq({tag, " empty_done_lat"}, done_cyc, 1);
    end else begin
      check_eq({tag, " first_lat"}, first_vld, LAT);
      if (mode == 0) begin
        check_eq({tag, " last_acc"}, last_acc, LAT + q.size() - 1);
        check_eq({tag, " done_lat"}, done_cyc, LAT + q.size() + DRAIN_X);
      end
    end

    if (done_cyc >= 0) begin
      check_eq({tag, " done_busy"}, int'(in_ready), 0);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      lo = 8'd1; hi = 8'd1; step = 8'd1;
      tick();
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check_eq({tag, " ack_outv"}, int'(out_valid), 0);
      check_eq({tag, " ack_idle"}, int'(in_ready), 1);
      check_eq({tag, " ack_nostart"}, int'(sOut_valid), 0);
    end
  endtask

  initial begin
    int s;
    int acc;
    int lo_v;
    int hi_v;
    int step_v;

    reset = 1'b1; in_valid = 1'b0; lo = '0; hi = '0; step = '0;
    sOut_ready = 1'b0; out_ready = 1'b0;
    #12;
    check_eq("rst in_ready", int'(in_ready), 1);
    check_eq("rst sOut", int'(sOut), 0);
    check_eq("rst sOut_valid", int'(sOut_valid), 0);
    check_eq("rst out_valid", int'(out_valid), 0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    run_range(1, 3, 1, 0, "t1", s);
    check_eq("t1 sum", s, 6);
    run_range(0, 10, 4, 0, "t2", s);
    run_range(254, 255, 1, 0, "t3", s);
    run_range(5, 2, 1, 0, "t4a", s);
    run_range(7, 7, 0, 0, "t4b", s);
    run_range(1, 4, 1, 2, "t5", s);

    lo = 8'd1; hi = 8'd9; step = 8'd1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    sOut_ready = 1'b1;
    acc = 0;
    for (int c = 0; c < 20 && acc < 2; c++) begin
      if (sOut_valid && sOut_ready) acc++;
      tick();
    end
    check_eq("t6 two_words", acc, 2);
    reset = 1'b1;
    #1;
    check_eq("t6 rst_vld", int'(sOut_valid), 0);
    check_eq("t6 rst_ready", int'(in_ready), 1);
    check_eq("t6 rst_outv", int'(out_valid), 0);
    #3;
    reset = 1'b0;
    tick();
    run_range(2, 3, 1, 0, "t6", s);

    for (int i = 0; i < 30; i++) begin
      lo_v = $urandom_range(0, 255);
      if ((i % 3) == 0) begin
        hi_v = $urandom_range(0, 255);
      end else begin
        hi_v = lo_v + $urandom_range(0, 20);
        if (hi_v > 255) hi_v = 255;
      end
      step_v = ((i % 5) == 4) ? $urandom_range(0, 255) : $urandom_range(0, 6);
      run_range(lo_v, hi_v, step_v, ((i % 4) == 0) ? 0 : 1, $sformatf("r%0d", i), s);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
